// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_gate.sv
// Glitch-free programmable clock divider with stop/start gating and
// a 4-phase request/acknowledge ratio-load port.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_gate #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_DIV = '0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LD,
    output logic             CLKO,
    output logic             ACK,
    output logic             ACTIVE
);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clko_q, clko_d;
    logic             ack_q, ack_d;
    logic             active_q, active_d;

    logic wrap;
    logic fall;

    // Exact-equality compare keeps every cur change at a cnt=0 instant.
    assign wrap = (cnt_q == cur_q);
    assign fall = (state_q != STOP) && wrap && clko_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= STOP;
            cnt_q    <= '0;
            cur_q    <= RST_DIV;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clko_q   <= 1'b0;
            ack_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clko_q   <= clko_d;
            ack_q    <= ack_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clko_d   = clko_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ack_d    = ack_q;

        unique case (state_q)
            STOP: begin
                cnt_d  = '0;
                clko_d = 1'b0;
                if (EN) state_d = RUN;
            end
            RUN: begin
                if (!EN && !clko_q) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    if (wrap) begin
                        cnt_d  = '0;
                        clko_d = !clko_q;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                    if (!EN) state_d = fall ? STOP : DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    clko_d = !clko_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                if (EN) state_d = RUN;
                else if (fall) state_d = STOP;
            end
            default: begin
                state_d = STOP;
                cnt_d   = '0;
                clko_d  = 1'b0;
            end
        endcase

        if (pend_v_q && (state_q == STOP || fall)) begin
            cur_d    = pend_q;
            pend_v_d = 1'b0;
            ack_d    = 1'b1;
        end else if (ack_q && !LD) begin
            ack_d = 1'b0;
        end

        if (LD && !ack_q && !pend_v_q) begin
            pend_d   = DIV;
            pend_v_d = 1'b1;
        end
    end

    always_comb begin
        active_d = (state_d != STOP);
        CLKO     = clko_q;
        ACK      = ack_q;
        ACTIVE   = active_q;
    end

    specify
        (CLK => CLKO) = 0;
        (CLK => ACK) = 0;
        (CLK => ACTIVE) = 0;
        (RN => CLKO) = 0;
        (RN => ACK) = 0;
        (RN => ACTIVE) = 0;
    endspecify

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_gate.sv
// Directed vector bench for the gated clock divider.
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_gate;

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] div;
        logic       clko;
        logic       ack;
        logic       act;
    } vec_t;

    logic       clk = 1'b0;
    logic       rn;
    logic       en;
    logic [3:0] div;
    logic       ld;
    logic       clko;
    logic       ack;
    logic       active;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    gf180mcu_osu_sc_gp12t3v3__clkdiv_gate #(
        .WIDTH  (4),
        .RST_DIV(4'd0)
    ) dut (
        .CLK   (clk),
        .RN    (rn),
        .EN    (en),
        .DIV   (div),
        .LD    (ld),
        .CLKO  (clko),
        .ACK   (ack),
        .ACTIVE(active)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic e, input logic l,
                                input logic [3:0] d, input logic c,
                                input logic a, input logic t);
        vec_t v;
        v.en = e; v.ld = l; v.div = d;
        v.clko = c; v.ack = a; v.act = t;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [2:0] exp);
        logic [2:0] got;
        got = {clko, ack, active};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: clko/ack/active got=%b expected=%b", nm, got, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        en = v.en; ld = v.ld; div = v.div;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), {v.clko, v.ack, v.act});
    endtask

    task automatic wait_sig(input bit use_ack, input logic val,
                            input int budget, input string nm);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((use_ack ? ack : clko) === val) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: timeout after %0d cycles, required %b", nm, budget, val);
        end
    endtask

    initial begin
        // Start at /2, then load DIV=2 mid-run.
        add(1,0,0, 0,0,1); add(1,0,0, 1,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 1,0,1); add(1,0,0, 0,0,1);
        add(1,1,2, 1,0,1); add(1,1,2, 0,1,1); add(1,1,2, 0,1,1);
        add(1,0,0, 0,0,1); add(1,0,0, 1,0,1); add(1,0,0, 1,0,1);
        add(1,0,0, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 0,0,1); add(1,0,0, 1,0,1);
        // Load DIV=3, then drop EN one cycle into a high phase.
        add(1,1,3, 1,0,1); add(1,1,3, 1,0,1); add(1,1,3, 0,1,1);
        add(1,0,0, 0,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 1,0,1);
        add(0,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 1,0,1);
        add(0,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        // Load DIV=7 while stopped, then restart.
        add(0,1,7, 0,0,0); add(0,1,7, 0,1,0); add(0,0,0, 0,0,0);
        add(1,0,0, 0,0,1);
        for (int i = 0; i < 7; i++) add(1,0,0, 0,0,1);
        for (int i = 0; i < 8; i++) add(1,0,0, 1,0,1);
        add(1,0,0, 0,0,1);
        // Load DIV=1; EN falls in the high phase so apply meets STOP.
        add(1,1,1, 0,0,1);
        for (int i = 0; i < 6; i++) add(1,1,5, 0,0,1);
        for (int i = 0; i < 4; i++) add(1,1,5, 1,0,1);
        for (int i = 0; i < 4; i++) add(0,1,5, 1,0,1);
        add(0,1,5, 0,1,0); add(0,0,0, 0,0,0);
        add(1,0,0, 0,0,1); add(1,0,0, 0,0,1); add(1,0,0, 1,0,1);
        add(1,0,0, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 1,0,1);

        rn = 1'b0; en = 1'b0; ld = 1'b0; div = '0;
        repeat (2) @(negedge clk);
        check("reset", 3'b000);
        rn = 1'b1;
        @(negedge clk);
        check("idle", 3'b000);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Async reset in the middle of a /10 high phase with ACK held.
        @(negedge clk);
        ld = 1'b1; div = 4'd4; en = 1'b1;
        wait_sig(1, 1'b1, 20, "ack_div4");
        wait_sig(0, 1'b0, 20, "clko_low_div4");
        wait_sig(0, 1'b1, 20, "clko_high_div4");
        repeat (2) @(posedge clk);
        #1;
        check("mid_high", 3'b111);
        #2 rn = 1'b0;
        #1;
        check("async_rst", 3'b000);
        @(negedge clk);
        ld = 1'b0; en = 1'b0;
        @(negedge clk);
        rn = 1'b1;
        begin
            vec_t v;
            v.en = 1; v.ld = 0; v.div = 0;
            v.clko = 0; v.ack = 0; v.act = 1;
            step(v, 900);
            v.clko = 1;
            step(v, 901);
            v.clko = 0;
            step(v, 902);
            v.clko = 1;
            step(v, 903);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
